entrada_numero: RTL and testbench
=================================

ENTRADA_NUMERO -- requirements
Module: entrada_numero

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning maximum BCD digits held in the entry buffer (range 1..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32'd500_000_000, meaning clk_nexys cycles of inactivity before a partial entry is discarded.
REQ-003 SHALL have port clk_nexys  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tecla_tick  input  1  one-cycle pulse: tecla holds a new released-key scan code.
REQ-006 SHALL have port tecla  input  8  PS/2 set-2 scan code of the released key.
REQ-007 SHALL have port numero  output  4*NUM_DIGITS  last confirmed number, packed BCD, least significant digit in [3:0].
REQ-008 SHALL have port num_valid  output  1  one-cycle pulse when numero is updated.
REQ-009 SHALL have port n_digitos  output  4  digits currently in the entry buffer.
REQ-010 SHALL have port editando  output  1  high while the FSM is in CAPTURA.
REQ-011 SHALL have port error  output  1  one-cycle pulse on a rejected key.

Function
REQ-012 SHALL decode digit codes: 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7, 3E->8, 46->9; control codes: 5A Enter, 66 Backspace, 76 Esc.
REQ-013 SHALL ignore every other code, including F0 and E0, with no state change and no error.
REQ-014 SHALL implement FSM states IDLE, CAPTURA, CONFIRMA.
REQ-015 SHALL, in IDLE, on a digit: load it as LSD, n_digitos=1, go to CAPTURA; Enter/Backspace in IDLE: error pulse, stay; Esc in IDLE: no effect.
REQ-016 SHALL, in CAPTURA, on a digit with n_digitos<NUM_DIGITS: shift buffer left one nibble, insert digit as LSD, increment n_digitos.
REQ-017 SHALL, on a digit with n_digitos==NUM_DIGITS (full): leave buffer unchanged, pulse error.
REQ-018 SHALL, on Backspace in CAPTURA: shift buffer right one nibble, zero-fill MSD, decrement n_digitos; reaching 0 returns to IDLE.
REQ-019 SHALL, on Esc in CAPTURA: clear buffer, n_digitos=0, go to IDLE; numero unchanged.
REQ-020 SHALL, on Enter in CAPTURA: go to CONFIRMA; in CONFIRMA (one cycle) copy buffer to numero, pulse num_valid, clear buffer and n_digitos, go to IDLE.
REQ-021 SHALL respond to a key with registered outputs exactly one cycle after tecla_tick (num_valid two cycles after Enter tick).
REQ-022 SHALL ignore a tecla_tick arriving while in CONFIRMA and pulse error.
REQ-023 SHALL run an inactivity counter in CAPTURA, cleared on every tecla_tick; reaching TIMEOUT_CYCLES-1 clears buffer and returns to IDLE with no error and no num_valid.
REQ-024 SHALL keep numero zero-extended: unused upper digits of a short entry read 0.

Reset
REQ-025 SHALL, while reset is low: state IDLE, buffer 0, numero 0, n_digitos 0, num_valid 0, editando 0, error 0, timeout counter 0.
REQ-026 SHALL discard any partial entry when reset asserts mid-entry; first tick after release is treated as from IDLE.

Configuration
REQ-027 SHALL, with KEYPAD_NUM_EN defined, also accept numeric-keypad codes 70->0, 69->1, 72->2, 7A->3, 6B->4, 73->5, 74->6, 6C->7, 75->8, 7D->9 as digits.
REQ-028 SHALL, without KEYPAD_NUM_EN, treat keypad codes as unknown (ignored per REQ-013).

Structure
REQ-029 SHALL place scan-code constants, control-key constants and the FSM state encoding in shared package teclado_pkg.
REQ-030 SHALL isolate the combinational scan-code-to-BCD lookup (digit, is_digit, is_ctrl outputs) in sub-module decodificador_tecla.

Verification
REQ-031 SHALL cover: codes 16,1E,26,25 then 5A (NUM_DIGITS=4) -> numero=16'h1234, one num_valid pulse, n_digitos back to 0.
REQ-032 SHALL cover: 16,1E,26,25,2E -> fifth key gives error pulse, buffer stays 1234; then 66,5A -> numero=16'h0123.
REQ-033 SHALL cover: 5A and 66 from IDLE -> error pulse each, numero unchanged; 76 in IDLE -> no pulse.
REQ-034 SHALL cover: 3D,3E then 76 -> editando falls, numero keeps previous value; 3D then TIMEOUT_CYCLES=100 idle cycles -> IDLE, no num_valid.
REQ-035 SHALL cover: 46,F0,45 then 5A -> F0 ignored, numero=16'h0090; with KEYPAD_NUM_EN, 69,72,5A -> numero=16'h0012, without it -> error on 5A.
REQ-036 SHALL cover: reset low after 16,1E -> all outputs 0 asynchronously; then 26,5A -> numero=16'h0003.

Source files
------------

// File: rtl/teclado_pkg.sv
// Shared PS/2 set-2 scan codes, control keys and entry FSM encoding.
// Keypad codes are consumed only when KEYPAD_NUM_EN is defined.
package teclado_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURA  = 2'd1,
        CONFIRMA = 2'd2
    } estado_t;

    localparam logic [7:0] SC_0 = 8'h45;
    localparam logic [7:0] SC_1 = 8'h16;
    localparam logic [7:0] SC_2 = 8'h1E;
    localparam logic [7:0] SC_3 = 8'h26;
    localparam logic [7:0] SC_4 = 8'h25;
    localparam logic [7:0] SC_5 = 8'h2E;
    localparam logic [7:0] SC_6 = 8'h36;
    localparam logic [7:0] SC_7 = 8'h3D;
    localparam logic [7:0] SC_8 = 8'h3E;
    localparam logic [7:0] SC_9 = 8'h46;

    localparam logic [7:0] KP_0 = 8'h70;
    localparam logic [7:0] KP_1 = 8'h69;
    localparam logic [7:0] KP_2 = 8'h72;
    localparam logic [7:0] KP_3 = 8'h7A;
    localparam logic [7:0] KP_4 = 8'h6B;
    localparam logic [7:0] KP_5 = 8'h73;
    localparam logic [7:0] KP_6 = 8'h74;
    localparam logic [7:0] KP_7 = 8'h6C;
    localparam logic [7:0] KP_8 = 8'h75;
    localparam logic [7:0] KP_9 = 8'h7D;

    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

endpackage

// File: rtl/decodificador_tecla.sv
// Combinational scan-code to BCD lookup; flags digits and control keys.
// Define KEYPAD_NUM_EN to also decode the numeric keypad digits.
module decodificador_tecla
    import teclado_pkg::*;
(
    input  logic [7:0] i_tecla,
    output logic [3:0] o_digit,
    output logic       o_is_digit,
    output logic       o_is_ctrl
);

    always_comb begin
        {o_is_digit, o_digit} = 5'h00;
        case (i_tecla)
            SC_0: {o_is_digit, o_digit} = 5'h10;
            SC_1: {o_is_digit, o_digit} = 5'h11;
            SC_2: {o_is_digit, o_digit} = 5'h12;
            SC_3: {o_is_digit, o_digit} = 5'h13;
            SC_4: {o_is_digit, o_digit} = 5'h14;
            SC_5: {o_is_digit, o_digit} = 5'h15;
            SC_6: {o_is_digit, o_digit} = 5'h16;
            SC_7: {o_is_digit, o_digit} = 5'h17;
            SC_8: {o_is_digit, o_digit} = 5'h18;
            SC_9: {o_is_digit, o_digit} = 5'h19;
`ifdef KEYPAD_NUM_EN
            KP_0: {o_is_digit, o_digit} = 5'h10;
            KP_1: {o_is_digit, o_digit} = 5'h11;
            KP_2: {o_is_digit, o_digit} = 5'h12;
            KP_3: {o_is_digit, o_digit} = 5'h13;
            KP_4: {o_is_digit, o_digit} = 5'h14;
            KP_5: {o_is_digit, o_digit} = 5'h15;
            KP_6: {o_is_digit, o_digit} = 5'h16;
            KP_7: {o_is_digit, o_digit} = 5'h17;
            KP_8: {o_is_digit, o_digit} = 5'h18;
            KP_9: {o_is_digit, o_digit} = 5'h19;
`endif
            default: {o_is_digit, o_digit} = 5'h00;
        endcase
    end

    assign o_is_ctrl = (i_tecla == SC_ENTER) || (i_tecla == SC_BKSP) || (i_tecla == SC_ESC);

endmodule

// File: rtl/entrada_numero.sv
// Keyboard number entry: collects up to NUM_DIGITS BCD digits, confirms on Enter.
// Build option: KEYPAD_NUM_EN adds numeric-keypad digits (see decodificador_tecla).
module entrada_numero
    import teclado_pkg::*;
#(
    parameter int          NUM_DIGITS     = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic                    clk_nexys,
    input  logic                    reset,
    input  logic                    tecla_tick,
    input  logic [7:0]              tecla,
    output logic [4*NUM_DIGITS-1:0] numero,
    output logic                    num_valid,
    output logic [3:0]              n_digitos,
    output logic                    editando,
    output logic                    error
);

    localparam int         W       = 4 * NUM_DIGITS;
    localparam logic [3:0] MAX_DIG = 4'(NUM_DIGITS);

    estado_t        r_estado, w_estado_next;
    logic [W-1:0]   r_buf, w_buf_next;
    logic [W-1:0]   r_numero, w_numero_next;
    logic [3:0]     r_n, w_n_next;
    logic           r_valid, w_valid_next;
    logic           r_error, w_error_next;
    logic [31:0]    r_cnt, w_cnt_next;

    logic [3:0]     w_digit;
    logic           w_is_digit;
    logic           w_is_ctrl;

    decodificador_tecla u_dec (
        .i_tecla    (tecla),
        .o_digit    (w_digit),
        .o_is_digit (w_is_digit),
        .o_is_ctrl  (w_is_ctrl)
    );

    always_ff @(posedge clk_nexys or negedge reset) begin
        if (!reset) begin
            r_estado <= IDLE;
            r_buf    <= '0;
            r_numero <= '0;
            r_n      <= '0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_estado <= w_estado_next;
            r_buf    <= w_buf_next;
            r_numero <= w_numero_next;
            r_n      <= w_n_next;
            r_valid  <= w_valid_next;
            r_error  <= w_error_next;
            r_cnt    <= w_cnt_next;
        end
    end

    // The buffer is always zero whenever the FSM sits in IDLE, so loading the
    // first digit can simply overwrite it.
    always_comb begin
        w_estado_next = r_estado;
        w_buf_next    = r_buf;
        w_numero_next = r_numero;
        w_n_next      = r_n;
        w_valid_next  = 1'b0;
        w_error_next  = 1'b0;
        w_cnt_next    = '0;
        case (r_estado)
            IDLE: begin
                if (tecla_tick) begin
                    if (w_is_digit) begin
                        w_buf_next    = W'(w_digit);
                        w_n_next      = 4'd1;
                        w_estado_next = CAPTURA;
                    end else if (w_is_ctrl && (tecla != SC_ESC)) begin
                        w_error_next = 1'b1;
                    end
                end
            end
            CAPTURA: begin
                if (tecla_tick) begin
                    if (w_is_digit) begin
                        if (r_n < MAX_DIG) begin
                            w_buf_next = (r_buf << 4) | W'(w_digit);
                            w_n_next   = r_n + 4'd1;
                        end else begin
                            w_error_next = 1'b1;
                        end
                    end else if (w_is_ctrl) begin
                        case (tecla)
                            SC_BKSP: begin
                                w_buf_next = r_buf >> 4;
                                w_n_next   = r_n - 4'd1;
                                if (r_n == 4'd1) w_estado_next = IDLE;
                            end
                            SC_ESC: begin
                                w_buf_next    = '0;
                                w_n_next      = '0;
                                w_estado_next = IDLE;
                            end
                            default: w_estado_next = CONFIRMA;
                        endcase
                    end
                end else if (r_cnt == TIMEOUT_CYCLES - 32'd1) begin
                    w_buf_next    = '0;
                    w_n_next      = '0;
                    w_estado_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            CONFIRMA: begin
                w_numero_next = r_buf;
                w_valid_next  = 1'b1;
                w_buf_next    = '0;
                w_n_next      = '0;
                w_estado_next = IDLE;
                w_error_next  = tecla_tick;
            end
            default: begin
                w_buf_next    = '0;
                w_n_next      = '0;
                w_estado_next = IDLE;
            end
        endcase
    end

    assign numero    = r_numero;
    assign num_valid = r_valid;
    assign n_digitos = r_n;
    assign editando  = (r_estado == CAPTURA);
    assign error     = r_error;

endmodule

// File: tb/tb_entrada_numero.sv
// Directed bench for entrada_numero (NUM_DIGITS=4, TIMEOUT_CYCLES=100).
module tb_entrada_numero;

    logic        clk_nexys = 1'b0;
    logic        reset     = 1'b0;
    logic        tecla_tick = 1'b0;
    logic [7:0]  tecla     = 8'h00;
    logic [15:0] numero;
    logic        num_valid;
    logic [3:0]  n_digitos;
    logic        editando;
    logic        error;

    int vectors = 0;
    int miscompares = 0;
    int nv_cnt = 0;
    int err_cnt = 0;
    int nv0, e0;
    logic err_seen;

    entrada_numero #(.NUM_DIGITS(4), .TIMEOUT_CYCLES(32'd100)) dut (
        .clk_nexys  (clk_nexys),
        .reset      (reset),
        .tecla_tick (tecla_tick),
        .tecla      (tecla),
        .numero     (numero),
        .num_valid  (num_valid),
        .n_digitos  (n_digitos),
        .editando   (editando),
        .error      (error)
    );

    always #5 clk_nexys = ~clk_nexys;

    always @(negedge clk_nexys) begin
        if (num_valid === 1'b1) nv_cnt++;
        if (error === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; tick is sampled at the next posedge, response seen one negedge later.
    task automatic press(input logic [7:0] code);
        tecla = code;
        tecla_tick = 1'b1;
        @(negedge clk_nexys);
        err_seen = error;
        tecla_tick = 1'b0;
        @(negedge clk_nexys);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_nexys);
    endtask

    initial begin
        #12;
        check("rst_numero", 32'(numero), 32'h0);
        check("rst_ndig", 32'(n_digitos), 32'h0);
        check("rst_flags", {29'd0, num_valid, editando, error}, 32'h0);
        @(negedge clk_nexys);
        reset = 1'b1;
        @(negedge clk_nexys);

        // 1,2,3,4 Enter
        press(8'h16); check("first_digit_edit", 32'(editando), 32'h1);
        press(8'h1E); press(8'h26); press(8'h25);
        check("four_digits_n", 32'(n_digitos), 32'h4);
        nv0 = nv_cnt;
        press(8'h5A);
        idle(1);
        check("enter_numero", 32'(numero), 32'h1234);
        check("enter_one_pulse", 32'(nv_cnt - nv0), 32'h1);
        check("enter_n_zero", 32'(n_digitos), 32'h0);
        check("enter_edit_low", 32'(editando), 32'h0);

        // overflow then backspace
        press(8'h16); press(8'h1E); press(8'h26); press(8'h25);
        e0 = err_cnt;
        press(8'h2E);
        check("full_err_pulse", 32'(err_seen), 32'h1);
        check("full_err_count", 32'(err_cnt - e0), 32'h1);
        check("full_n", 32'(n_digitos), 32'h4);
        press(8'h66);
        check("bksp_n", 32'(n_digitos), 32'h3);
        press(8'h5A); idle(1);
        check("bksp_numero", 32'(numero), 32'h0123);
        check("valid_cleared", 32'(num_valid), 32'h0);

        // control keys from IDLE
        e0 = err_cnt;
        press(8'h5A); check("idle_enter_err", 32'(err_seen), 32'h1);
        press(8'h66); check("idle_bksp_err", 32'(err_seen), 32'h1);
        press(8'h76); check("idle_esc_noerr", 32'(err_seen), 32'h0);
        check("idle_err_count", 32'(err_cnt - e0), 32'h2);
        check("idle_numero", 32'(numero), 32'h0123);

        // Esc and timeout
        press(8'h3D); press(8'h3E);
        check("esc_pre_edit", 32'(editando), 32'h1);
        press(8'h76);
        check("esc_edit", 32'(editando), 32'h0);
        check("esc_n", 32'(n_digitos), 32'h0);
        check("esc_numero", 32'(numero), 32'h0123);
        nv0 = nv_cnt; e0 = err_cnt;
        press(8'h3D);
        idle(90);
        check("to_still_edit", 32'(editando), 32'h1);
        idle(15);
        check("to_edit_low", 32'(editando), 32'h0);
        check("to_n_zero", 32'(n_digitos), 32'h0);
        check("to_no_valid", 32'(nv_cnt - nv0), 32'h0);
        check("to_no_err", 32'(err_cnt - e0), 32'h0);
        check("to_numero", 32'(numero), 32'h0123);

        // break code ignored
        press(8'h46); press(8'hF0);
        check("f0_noerr", 32'(err_seen), 32'h0);
        check("f0_n", 32'(n_digitos), 32'h1);
        press(8'h45); press(8'h5A); idle(1);
        check("f0_numero", 32'(numero), 32'h0090);

        // keypad digits
        e0 = err_cnt;
        press(8'h69); press(8'h72); press(8'h5A); idle(1);
`ifdef KEYPAD_NUM_EN
        check("kp_numero", 32'(numero), 32'h0012);
        check("kp_err", 32'(err_cnt - e0), 32'h0);
`else
        check("kp_numero", 32'(numero), 32'h0090);
        check("kp_err", 32'(err_cnt - e0), 32'h1);
`endif

        // tick during CONFIRMA
        press(8'h16);
        tecla = 8'h5A; tecla_tick = 1'b1;
        @(negedge clk_nexys);
        tecla = 8'h1E;
        @(negedge clk_nexys);
        check("conf_err", 32'(error), 32'h1);
        check("conf_valid", 32'(num_valid), 32'h1);
        check("conf_numero", 32'(numero), 32'h0001);
        tecla_tick = 1'b0;
        @(negedge clk_nexys);
        check("conf_ignored_n", 32'(n_digitos), 32'h0);
        check("conf_ignored_edit", 32'(editando), 32'h0);

        // async reset mid-entry
        press(8'h16); press(8'h1E);
        #2 reset = 1'b0;
        #1;
        check("arst_numero", 32'(numero), 32'h0);
        check("arst_n", 32'(n_digitos), 32'h0);
        check("arst_flags", {29'd0, num_valid, editando, error}, 32'h0);
        @(negedge clk_nexys);
        reset = 1'b1;
        @(negedge clk_nexys);
        press(8'h26); press(8'h5A); idle(1);
        check("arst_after_numero", 32'(numero), 32'h0003);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
